// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the instruction-fetch stage.
package pc_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_STEP  = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_PC = '0;

  // Sign-extended 16-bit word offset, scaled to bytes, at the widest legal PC width.
  function automatic logic [63:0] word_offset(input logic [15:0] imm);
    return {{46{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_pipe_reg.sv
// IF/ID boundary register: priority is reset, then flush, then enable; otherwise it holds.
module pc_pipe_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid_q
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_r_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_r_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_r_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_r_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign valid_q = valid_r_q;

endmodule

// File: rtl/pc_adder.sv
// Sequential next-PC adder with wrap/misaligned status and a registered copy for IF/ID.
// Defining PC_ADDER_BRANCH_EN adds the branch-target adder and its registered copy.
module pc_adder
  import pc_pkg::*;
#(
  parameter int unsigned       size = PC_WIDTH,
  parameter longint unsigned   STEP = PC_STEP
) (
  input  logic [size-1:0] oldpc,
  output logic [size-1:0] pc_plus_4,
  input  logic            clk,
  input  logic            reset,
  output logic            wrap,
  output logic            misaligned,
  input  logic            en,
  input  logic            flush,
  output logic [size-1:0] pc_plus_4_q,
`ifdef PC_ADDER_BRANCH_EN
  input  logic [15:0]     imm,
  output logic [size-1:0] branch_target,
  output logic [size-1:0] branch_target_q,
`endif
  output logic            valid_q
);

  // One extra bit captures the carry out of the top PC bit.
  logic [size:0] sum;

  assign sum        = {1'b0, oldpc} + (size+1)'(STEP);
  assign pc_plus_4  = sum[size-1:0];
  assign wrap       = sum[size];
  assign misaligned = (oldpc[1:0] != 2'b00);

`ifdef PC_ADDER_BRANCH_EN
  logic [2*size-1:0] reg_d, reg_q;

  assign branch_target = pc_plus_4 + size'(word_offset(imm));
  assign reg_d         = {branch_target, pc_plus_4};

  pc_pipe_reg #(.W(2*size)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .en      (en),
    .d       (reg_d),
    .q       (reg_q),
    .valid_q (valid_q)
  );

  assign pc_plus_4_q     = reg_q[size-1:0];
  assign branch_target_q = reg_q[2*size-1:size];
`else
  pc_pipe_reg #(.W(size)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .en      (en),
    .d       (pc_plus_4),
    .q       (pc_plus_4_q),
    .valid_q (valid_q)
  );
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Directed self-checking bench for pc_adder (32-bit default build; branch checks under PC_ADDER_BRANCH_EN).
module tb_pc_adder;

  logic        clk;
  logic        reset;
  logic [31:0] oldpc;
  logic [31:0] pc_plus_4;
  logic        wrap;
  logic        misaligned;
  logic        en;
  logic        flush;
  logic [31:0] pc_plus_4_q;
  logic        valid_q;
`ifdef PC_ADDER_BRANCH_EN
  logic [15:0] imm;
  logic [31:0] branch_target;
  logic [31:0] branch_target_q;
`endif

  int total = 0;
  int bad   = 0;

  pc_adder dut (
    .oldpc           (oldpc),
    .pc_plus_4       (pc_plus_4),
    .clk             (clk),
    .reset           (reset),
    .wrap            (wrap),
    .misaligned      (misaligned),
    .en              (en),
    .flush           (flush),
    .pc_plus_4_q     (pc_plus_4_q),
`ifdef PC_ADDER_BRANCH_EN
    .imm             (imm),
    .branch_target   (branch_target),
    .branch_target_q (branch_target_q),
`endif
    .valid_q         (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] pc, input logic r,
                               input logic e, input logic f);
    oldpc = pc;
    reset = r;
    en    = e;
    flush = f;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PC_ADDER_BRANCH_EN
    imm = 16'h0000;
`endif
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc0", pc_plus_4, 32'h4);
    checkOutput("wrap0", {31'b0, wrap}, 32'h0);
    checkOutput("mis0", {31'b0, misaligned}, 32'h0);
    #99;
    applyStimulus(32'h4, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc4", pc_plus_4, 32'h8);
    checkOutput("rst_q", pc_plus_4_q, 32'h0);
    checkOutput("rst_v", {31'b0, valid_q}, 32'h0);
    #99;
    applyStimulus(32'hC, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc12", pc_plus_4, 32'h10);
    checkOutput("wrap12", {31'b0, wrap}, 32'h0);
    checkOutput("mis12", {31'b0, misaligned}, 32'h0);

    applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc_top", pc_plus_4, 32'h0);
    checkOutput("wrap_top", {31'b0, wrap}, 32'h1);
    applyStimulus(32'h7FFF_FFFC, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc_mid", pc_plus_4, 32'h8000_0000);
    checkOutput("wrap_mid", {31'b0, wrap}, 32'h0);
    applyStimulus(32'h2, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pc_unal", pc_plus_4, 32'h6);
    checkOutput("mis_unal", {31'b0, misaligned}, 32'h1);

    // Reset held for two edges with capture requested.
    @(negedge clk);
    applyStimulus(32'h100, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("rst1_q", pc_plus_4_q, 32'h0);
    checkOutput("rst1_v", {31'b0, valid_q}, 32'h0);
    tick();
    checkOutput("rst2_q", pc_plus_4_q, 32'h0);
    checkOutput("rst2_v", {31'b0, valid_q}, 32'h0);
    @(negedge clk);
    applyStimulus(32'h100, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("cap_q", pc_plus_4_q, 32'h104);
    checkOutput("cap_v", {31'b0, valid_q}, 32'h1);

    @(negedge clk);
    applyStimulus(32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("hold_q", pc_plus_4_q, 32'h104);
    checkOutput("hold_v", {31'b0, valid_q}, 32'h1);
    checkOutput("hold_comb", pc_plus_4, 32'h204);

    @(negedge clk);
    applyStimulus(32'h40, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_q", pc_plus_4_q, 32'h0);
    checkOutput("flush_v", {31'b0, valid_q}, 32'h0);

    @(negedge clk);
    applyStimulus(32'h40, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("recap_q", pc_plus_4_q, 32'h44);
    checkOutput("recap_v", {31'b0, valid_q}, 32'h1);

    // Mid-operation reset clears the register but not the adder.
    @(negedge clk);
    applyStimulus(32'h44, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("prerst_q", pc_plus_4_q, 32'h44);
    tick();
    checkOutput("midrst_q", pc_plus_4_q, 32'h0);
    checkOutput("midrst_v", {31'b0, valid_q}, 32'h0);
    checkOutput("midrst_comb", pc_plus_4, 32'h48);

`ifdef PC_ADDER_BRANCH_EN
    @(negedge clk);
    applyStimulus(32'h1000, 1'b0, 1'b1, 1'b0);
    imm = 16'hFFFF;
    #1;
    checkOutput("bt_neg", branch_target, 32'h1000);
    imm = 16'h0003;
    #1;
    checkOutput("bt_pos", branch_target, 32'h1010);
    tick();
    checkOutput("bt_q", branch_target_q, 32'h1010);
    @(negedge clk);
    applyStimulus(32'h1000, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("bt_flush", branch_target_q, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
